// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states, geometry and checksum seed.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_DEPTH     = 64;

    localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into a word and keeps a running XOR of them.
// word/word_ready are combinational on the accepting cycle; no backpressure of its own.
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept,
    input  logic [7:0]    data_byte,
    output logic          word_ready,
    output logic [DW-1:0] word,
    output logic [7:0]    xor_sum
);

    logic [1:0]    idx;
    logic [DW-1:0] word_q;
    logic [7:0]    acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            word_q <= '0;
            acc_q  <= CSUM_SEED;
        end else if (clear) begin
            idx    <= '0;
            acc_q  <= CSUM_SEED;
        end else if (accept) begin
            word_q <= word;
            acc_q  <= acc_q ^ data_byte;
            idx    <= (idx == 2'(BYTES_PER_WORD - 1)) ? 2'd0 : idx + 2'd1;
        end
    end

    // Merge the incoming byte so the full word is visible on the 4th byte's edge.
    always_comb begin
        word = word_q;
        if (accept) begin
            word[{idx, 3'b000} +: 8] = data_byte;
        end
    end

    assign word_ready = accept && (idx == 2'(BYTES_PER_WORD - 1));
    assign xor_sum    = acc_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header N, 4*N little-endian data bytes, XOR checksum; writes words to imem.
// Write one cycle after the 4th byte; ready drops for that write bubble and after DONE/ERR.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    output logic [AW-1:0] wraddr_o,
    output logic [DW-1:0] wrdata_o,
    output logic          wren_o,
    output logic          cpu_rst_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   words_o
);

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t        state;
    state_t        next_state;
    logic [7:0]    n_q;
    logic          accept;
    logic          hdr_bad;
    logic [AW:0]   words_inc;
    logic          word_ready;
    logic [DW-1:0] word;
    logic [7:0]    xor_sum;

    logic          ready_nxt;
    logic          wren_nxt;
    logic [AW-1:0] wraddr_nxt;
    logic [DW-1:0] wrdata_nxt;
    logic          cpu_rst_nxt;
    logic          done_nxt;
    logic          err_nxt;

    assign accept    = byte_valid_i && byte_ready_o;
    assign hdr_bad   = (byte_i == 8'd0) || ({1'b0, byte_i} > DEPTH_W);
    assign words_inc = words_o + 1'b1;

    imem_word_packer #(.DW(DW)) u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (accept && (state == HDR)),
        .accept     (accept && (state == DATA)),
        .data_byte  (byte_i),
        .word_ready (word_ready),
        .word       (word),
        .xor_sum    (xor_sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= HDR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HDR:   if (accept) next_state = hdr_bad ? ERR : DATA;
            DATA:  if (word_ready) next_state = WRITE;
            WRITE: next_state = (8'(words_inc) == n_q) ? CSUM : DATA;
            CSUM:  if (accept) next_state = (byte_i == xor_sum) ? DONE : ERR;
            DONE:  next_state = DONE;
            ERR:   next_state = ERR;
            default: next_state = HDR;
        endcase
    end

    // Outputs are computed from next_state and registered, so every port is a flop.
    always_comb begin
        ready_nxt   = (next_state == HDR) || (next_state == DATA) || (next_state == CSUM);
        wren_nxt    = (next_state == WRITE);
        wraddr_nxt  = wraddr_o;
        wrdata_nxt  = wrdata_o;
        cpu_rst_nxt = (next_state != DONE);
        done_nxt    = (next_state == DONE);
        err_nxt     = (next_state == ERR);
        if (next_state == WRITE) begin
            wraddr_nxt = words_o[AW-1:0];
            wrdata_nxt = word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_ready_o <= 1'b1;
            wren_o       <= 1'b0;
            wraddr_o     <= '0;
            wrdata_o     <= '0;
            cpu_rst_o    <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            words_o      <= '0;
            n_q          <= '0;
        end else begin
            byte_ready_o <= ready_nxt;
            wren_o       <= wren_nxt;
            wraddr_o     <= wraddr_nxt;
            wrdata_o     <= wrdata_nxt;
            cpu_rst_o    <= cpu_rst_nxt;
            done_o       <= done_nxt;
            err_o        <= err_nxt;
            if (state == HDR && accept) begin
                n_q <= byte_i;
            end
            if (state == WRITE) begin
                words_o <= words_inc;
            end
        end
    end

endmodule
